// File: rtl/uart_duplex.sv
// Full-duplex UART: tick-enable baud timing, RX/TX FIFOs, parity, sticky errors and RTS/CTS.
// Everything runs on i_clk; i_rx and i_cts are the only asynchronous inputs.
module uart_duplex #(
  parameter int DataLength      = 8,
  parameter int FifoDepth       = 8,
  parameter int OverSample      = 8,
  parameter int BaudRate        = 115200,
  parameter int SystemClockFreq = 50_000_000,
  parameter int ParityMode      = 0,
  parameter int StopBits        = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DataLength-1:0] i_tx_data,
  input  logic                  i_tx_req,
  output logic                  o_tx_full,
  output logic                  o_tx_busy,
  input  logic                  i_rx_req,
  output logic [DataLength-1:0] o_rx_data,
  output logic                  o_rx_rdy,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_overrun,
  input  logic                  i_clr_err,
  input  logic                  i_rx,
  output logic                  o_tx,
  input  logic                  i_cts,
  output logic                  o_rts
);

  localparam int DivRaw = (2 * SystemClockFreq / (BaudRate * OverSample) + 1) / 2;
  localparam int Div    = (DivRaw < 1) ? 1 : DivRaw;
  localparam int TickW  = (Div > 1) ? $clog2(Div) : 1;
  localparam int OsW    = $clog2(OverSample);
  localparam int BitW   = $clog2(DataLength + 1);
  localparam int AW     = $clog2(FifoDepth);
  localparam int PtrW   = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  function automatic logic f_parity(input logic [DataLength-1:0] d);
    return (ParityMode == 2) ? ~(^d) : (^d);
  endfunction

  logic [TickW-1:0] r_tick_cnt;
  logic             r_tick;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
    end else if (r_tick_cnt == TickW'(Div - 1)) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b1;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
      r_tick     <= 1'b0;
    end
  end

  // Two-flop synchronisers; r_rx_prev gives the falling-edge reference for frame detection.
  logic r_rx_meta, r_rx_sync, r_rx_prev, r_cts_meta, r_cts_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_cts_meta <= 1'b1;
      r_cts_sync <= 1'b1;
    end else begin
      r_rx_meta  <= i_rx;
      r_rx_sync  <= r_rx_meta;
      r_rx_prev  <= r_rx_sync;
      r_cts_meta <= i_cts;
      r_cts_sync <= r_cts_meta;
    end
  end

  state_t                r_rx_state;
  logic [OsW-1:0]        r_rx_tcnt;
  logic [BitW-1:0]       r_rx_bcnt;
  logic [DataLength-1:0] r_rx_shift;
  logic                  r_rx_par;
  logic                  r_rx_wr;
  logic [DataLength-1:0] r_rx_wdata;
  logic                  r_perr_set;
  logic                  r_ferr_set;
  logic                  w_rx_sample;

  assign w_rx_sample = r_tick && (r_rx_tcnt == OsW'(OverSample - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rx_state <= S_IDLE;
      r_rx_tcnt  <= '0;
      r_rx_bcnt  <= '0;
      r_rx_shift <= '0;
      r_rx_par   <= 1'b0;
      r_rx_wr    <= 1'b0;
      r_rx_wdata <= '0;
      r_perr_set <= 1'b0;
      r_ferr_set <= 1'b0;
    end else begin
      r_rx_wr    <= 1'b0;
      r_perr_set <= 1'b0;
      r_ferr_set <= 1'b0;
      if (r_rx_state != S_IDLE && r_rx_state != S_START && r_tick)
        r_rx_tcnt <= w_rx_sample ? '0 : r_rx_tcnt + 1'b1;
      case (r_rx_state)
        S_IDLE: begin
          if (r_rx_prev && !r_rx_sync) begin
            r_rx_state <= S_START;
            r_rx_tcnt  <= '0;
          end
        end
        S_START: begin
          // Half a bit in: a line that is high again was only a glitch.
          if (r_tick) begin
            if (r_rx_tcnt == OsW'(OverSample / 2 - 1)) begin
              r_rx_tcnt  <= '0;
              r_rx_bcnt  <= '0;
              r_rx_state <= r_rx_sync ? S_IDLE : S_DATA;
            end else begin
              r_rx_tcnt <= r_rx_tcnt + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (w_rx_sample) begin
            r_rx_shift <= {r_rx_sync, r_rx_shift[DataLength-1:1]};
            if (r_rx_bcnt == BitW'(DataLength - 1))
              r_rx_state <= (ParityMode == 0) ? S_STOP : S_PARITY;
            else
              r_rx_bcnt <= r_rx_bcnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (w_rx_sample) begin
            r_rx_par   <= r_rx_sync;
            r_rx_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_rx_sample) begin
            r_rx_state <= S_IDLE;
            if (!r_rx_sync)
              r_ferr_set <= 1'b1;
            else if (ParityMode != 0 && r_rx_par != f_parity(r_rx_shift))
              r_perr_set <= 1'b1;
            else begin
              r_rx_wr    <= 1'b1;
              r_rx_wdata <= r_rx_shift;
            end
          end
        end
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

  logic [DataLength-1:0] r_rx_mem [FifoDepth];
  logic [PtrW-1:0]       r_rx_wptr, r_rx_rptr;
  logic [PtrW-1:0]       w_rx_count;
  logic                  w_rx_empty, w_rx_full, w_rx_pop, w_rx_push;

  assign w_rx_count = r_rx_wptr - r_rx_rptr;
  assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
  assign w_rx_full  = (w_rx_count == PtrW'(FifoDepth));
  assign w_rx_pop   = i_rx_req && !w_rx_empty;
  assign w_rx_push  = r_rx_wr && (!w_rx_full || w_rx_pop);

  always_ff @(posedge i_clk) begin
    if (w_rx_push)
      r_rx_mem[r_rx_wptr[AW-1:0]] <= r_rx_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
    end
  end

  assign o_rx_data = w_rx_empty ? '0 : r_rx_mem[r_rx_rptr[AW-1:0]];
  assign o_rx_rdy  = !w_rx_empty;

  // Sticky flags: a set in the same cycle as a clear wins.
  logic r_perr, r_ferr, r_ovr, r_rts;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
      r_rts  <= 1'b1;
    end else begin
      r_perr <= r_perr_set | (r_perr & ~i_clr_err);
      r_ferr <= r_ferr_set | (r_ferr & ~i_clr_err);
      r_ovr  <= (r_rx_wr & ~w_rx_push) | (r_ovr & ~i_clr_err);
      r_rts  <= (w_rx_count >= PtrW'(FifoDepth - 1));
    end
  end

  assign o_parity_err = r_perr;
  assign o_frame_err  = r_ferr;
  assign o_overrun    = r_ovr;
  assign o_rts        = r_rts;

  logic [DataLength-1:0] r_tx_mem [FifoDepth];
  logic [PtrW-1:0]       r_tx_wptr, r_tx_rptr;
  logic [PtrW-1:0]       w_tx_count;
  logic                  w_tx_empty, w_tx_full, w_tx_start, w_tx_push;
  logic [DataLength-1:0] w_tx_head;
  state_t                r_tx_state;

  assign w_tx_count = r_tx_wptr - r_tx_rptr;
  assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
  assign w_tx_full  = (w_tx_count == PtrW'(FifoDepth));
  assign w_tx_head  = r_tx_mem[r_tx_rptr[AW-1:0]];
  assign w_tx_start = (r_tx_state == S_IDLE) && r_tick && !w_tx_empty && !r_cts_sync;
  assign w_tx_push  = i_tx_req && (!w_tx_full || w_tx_start);

  always_ff @(posedge i_clk) begin
    if (w_tx_push)
      r_tx_mem[r_tx_wptr[AW-1:0]] <= i_tx_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
    end else begin
      if (w_tx_push)  r_tx_wptr <= r_tx_wptr + 1'b1;
      if (w_tx_start) r_tx_rptr <= r_tx_rptr + 1'b1;
    end
  end

  logic [OsW-1:0]        r_tx_tcnt;
  logic [BitW-1:0]       r_tx_bcnt;
  logic [DataLength-1:0] r_tx_shift;
  logic                  r_tx_par;
  logic                  r_tx;
  logic                  w_tx_bitend;

  assign w_tx_bitend = r_tick && (r_tx_tcnt == OsW'(OverSample - 1));

  // CTS only gates the start of a frame; once out of IDLE the frame always finishes.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tx_state <= S_IDLE;
      r_tx_tcnt  <= '0;
      r_tx_bcnt  <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      if (r_tx_state != S_IDLE && r_tick)
        r_tx_tcnt <= w_tx_bitend ? '0 : r_tx_tcnt + 1'b1;
      case (r_tx_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_tx_start) begin
            r_tx_shift <= w_tx_head;
            r_tx_par   <= f_parity(w_tx_head);
            r_tx_tcnt  <= '0;
            r_tx       <= 1'b0;
            r_tx_state <= S_START;
          end
        end
        S_START: begin
          if (w_tx_bitend) begin
            r_tx       <= r_tx_shift[0];
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_bcnt  <= '0;
            r_tx_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_tx_bitend) begin
            if (r_tx_bcnt == BitW'(DataLength - 1)) begin
              r_tx_bcnt <= '0;
              if (ParityMode != 0) begin
                r_tx       <= r_tx_par;
                r_tx_state <= S_PARITY;
              end else begin
                r_tx       <= 1'b1;
                r_tx_state <= S_STOP;
              end
            end else begin
              r_tx       <= r_tx_shift[0];
              r_tx_shift <= r_tx_shift >> 1;
              r_tx_bcnt  <= r_tx_bcnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (w_tx_bitend) begin
            r_tx       <= 1'b1;
            r_tx_bcnt  <= '0;
            r_tx_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_tx_bitend) begin
            if (r_tx_bcnt == BitW'(StopBits - 1))
              r_tx_state <= S_IDLE;
            else
              r_tx_bcnt <= r_tx_bcnt + 1'b1;
          end
        end
        default: r_tx_state <= S_IDLE;
      endcase
    end
  end

  assign o_tx      = r_tx;
  assign o_tx_full = w_tx_full;
  assign o_tx_busy = (r_tx_state != S_IDLE) || !w_tx_empty;

endmodule

// File: tb/tb_uart_duplex.sv
// Directed bench for uart_duplex: one even-parity instance (loopback, flow control, errors)
// and one odd-parity instance for the parity checks. One bit = 16 clocks.
module tb_uart_duplex;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;

  logic       loopEn = 1'b0;
  logic       evenRxDrv = 1'b1;
  logic       oddRxDrv = 1'b1;

  logic [7:0] evenTxData = '0;
  logic       evenTxReq = 1'b0;
  logic       evenTxFull, evenTxBusy;
  logic       evenRxReq = 1'b0;
  logic [7:0] evenRxData;
  logic       evenRxRdy, evenPerr, evenFerr, evenOvr;
  logic       evenClr = 1'b0;
  logic       evenRx, evenTx;
  logic       evenCts = 1'b0;
  logic       evenRts;

  logic [7:0] oddTxData = '0;
  logic       oddTxReq = 1'b0;
  logic       oddTxFull, oddTxBusy;
  logic       oddRxReq = 1'b0;
  logic [7:0] oddRxData;
  logic       oddRxRdy, oddPerr, oddFerr, oddOvr;
  logic       oddClr = 1'b0;
  logic       oddTx;
  logic       oddCts = 1'b0;
  logic       oddRts;

  assign evenRx = loopEn ? evenTx : evenRxDrv;

  always #5 clk = ~clk;

  uart_duplex #(
    .DataLength(8), .FifoDepth(8), .OverSample(8), .BaudRate(115200),
    .SystemClockFreq(1_843_200), .ParityMode(1), .StopBits(1)
  ) u_even (
    .i_clk(clk), .i_rst_n(rstN), .i_tx_data(evenTxData), .i_tx_req(evenTxReq),
    .o_tx_full(evenTxFull), .o_tx_busy(evenTxBusy), .i_rx_req(evenRxReq),
    .o_rx_data(evenRxData), .o_rx_rdy(evenRxRdy), .o_parity_err(evenPerr),
    .o_frame_err(evenFerr), .o_overrun(evenOvr), .i_clr_err(evenClr),
    .i_rx(evenRx), .o_tx(evenTx), .i_cts(evenCts), .o_rts(evenRts)
  );

  uart_duplex #(
    .DataLength(8), .FifoDepth(8), .OverSample(8), .BaudRate(115200),
    .SystemClockFreq(1_843_200), .ParityMode(2), .StopBits(1)
  ) u_odd (
    .i_clk(clk), .i_rst_n(rstN), .i_tx_data(oddTxData), .i_tx_req(oddTxReq),
    .o_tx_full(oddTxFull), .o_tx_busy(oddTxBusy), .i_rx_req(oddRxReq),
    .o_rx_data(oddRxData), .o_rx_rdy(oddRxRdy), .o_parity_err(oddPerr),
    .o_frame_err(oddFerr), .o_overrun(oddOvr), .i_clr_err(oddClr),
    .i_rx(oddRxDrv), .o_tx(oddTx), .i_cts(oddCts), .o_rts(oddRts)
  );

  task automatic drive_bit(input bit toOdd, input logic v);
    if (toOdd) oddRxDrv = v;
    else       evenRxDrv = v;
    repeat (16) @(negedge clk);
  endtask

  // Serial frame onto a DUT's i_rx: start, 8 data LSB first, parity, stop, then 4 idle clocks.
  task automatic applyStimulus(input bit toOdd, input logic [7:0] data,
                               input logic par, input logic stopBit);
    drive_bit(toOdd, 1'b0);
    for (int k = 0; k < 8; k++) drive_bit(toOdd, data[k]);
    drive_bit(toOdd, par);
    drive_bit(toOdd, stopBit);
    if (toOdd) oddRxDrv = 1'b1;
    else       evenRxDrv = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic decode_tx(output logic [7:0] d, output logic p, output logic s,
                           output bit found);
    found = 1'b0;
    d = '0;
    p = 1'b0;
    s = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (evenTx === 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (found) begin
      repeat (8) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (16) @(negedge clk);
        d[k] = evenTx;
      end
      repeat (16) @(negedge clk);
      p = evenTx;
      repeat (16) @(negedge clk);
      s = evenTx;
    end
  endtask

  task automatic test_reset;
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (evenTx !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_tx: got %b want 1", evenTx); end
    vectors++; if (evenRts !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_rts: got %b want 1", evenRts); end
    vectors++; if (evenRxData !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_rx_data: got %h want 00", evenRxData); end
    vectors++; if (evenTxFull !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tx_full: got %b want 0", evenTxFull); end
    vectors++; if (evenTxBusy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tx_busy: got %b want 0", evenTxBusy); end
    vectors++; if (evenRxRdy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rx_rdy: got %b want 0", evenRxRdy); end
    vectors++; if ({evenPerr, evenFerr, evenOvr} !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_flags: got %b want 000", {evenPerr, evenFerr, evenOvr}); end
    rstN = 1'b1;
    repeat (4) @(negedge clk);
    vectors++; if (evenRts !== 1'b0) begin miscompares++; $display("[TB] FAIL rts_after_reset: got %b want 0", evenRts); end
  endtask

  task automatic test_loopback;
    logic [10:0] expBits;
    bit          found;
    expBits = {1'b1, 1'b0, 8'hA5, 1'b0};
    loopEn = 1'b1;
    evenTxData = 8'hA5;
    evenTxReq = 1'b1;
    @(negedge clk);
    evenTxReq = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (evenTx === 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    vectors++; if (found !== 1'b1) begin miscompares++; $display("[TB] FAIL loop_start: got %b want 1", found); end
    for (int m = 0; m < 176; m++) begin
      if (m % 16 == 8) begin
        vectors++; if (evenTx !== expBits[m/16]) begin miscompares++; $display("[TB] FAIL loop_bit%0d: got %b want %b", m / 16, evenTx, expBits[m/16]); end
      end
      if (m == 159) begin
        vectors++; if (evenTx !== 1'b0) begin miscompares++; $display("[TB] FAIL loop_parity_end: got %b want 0", evenTx); end
      end
      if (m == 160) begin
        vectors++; if (evenTx !== 1'b1) begin miscompares++; $display("[TB] FAIL loop_stop_begin: got %b want 1", evenTx); end
      end
      @(negedge clk);
    end
    for (int i = 0; i < 40 && evenRxRdy !== 1'b1; i++) @(negedge clk);
    vectors++; if (evenRxRdy !== 1'b1) begin miscompares++; $display("[TB] FAIL loop_rx_rdy: got %b want 1", evenRxRdy); end
    vectors++; if (evenRxData !== 8'hA5) begin miscompares++; $display("[TB] FAIL loop_rx_data: got %h want a5", evenRxData); end
    vectors++; if ({evenPerr, evenFerr, evenOvr} !== 3'b000) begin miscompares++; $display("[TB] FAIL loop_flags: got %b want 000", {evenPerr, evenFerr, evenOvr}); end
    evenRxReq = 1'b1;
    @(negedge clk);
    evenRxReq = 1'b0;
    vectors++; if (evenRxRdy !== 1'b0) begin miscompares++; $display("[TB] FAIL loop_pop: got %b want 0", evenRxRdy); end
    loopEn = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_frame_error;
    applyStimulus(1'b0, 8'h3C, 1'b0, 1'b0);
    vectors++; if (evenFerr !== 1'b1) begin miscompares++; $display("[TB] FAIL ferr_set: got %b want 1", evenFerr); end
    vectors++; if (evenRxRdy !== 1'b0) begin miscompares++; $display("[TB] FAIL ferr_rdy: got %b want 0", evenRxRdy); end
    vectors++; if (evenPerr !== 1'b0) begin miscompares++; $display("[TB] FAIL ferr_perr: got %b want 0", evenPerr); end
    evenClr = 1'b1;
    @(negedge clk);
    evenClr = 1'b0;
    vectors++; if (evenFerr !== 1'b0) begin miscompares++; $display("[TB] FAIL ferr_clear: got %b want 0", evenFerr); end
  endtask

  task automatic test_parity;
    applyStimulus(1'b1, 8'h01, 1'b1, 1'b1);
    vectors++; if (oddPerr !== 1'b1) begin miscompares++; $display("[TB] FAIL perr_set: got %b want 1", oddPerr); end
    vectors++; if (oddRxRdy !== 1'b0) begin miscompares++; $display("[TB] FAIL perr_discard: got %b want 0", oddRxRdy); end
    oddClr = 1'b1;
    @(negedge clk);
    oddClr = 1'b0;
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b1);
    for (int i = 0; i < 40 && oddRxRdy !== 1'b1; i++) @(negedge clk);
    vectors++; if (oddRxRdy !== 1'b1) begin miscompares++; $display("[TB] FAIL parity_ok_rdy: got %b want 1", oddRxRdy); end
    vectors++; if (oddRxData !== 8'h01) begin miscompares++; $display("[TB] FAIL parity_ok_data: got %h want 01", oddRxData); end
    vectors++; if (oddPerr !== 1'b0) begin miscompares++; $display("[TB] FAIL parity_ok_perr: got %b want 0", oddPerr); end
    oddRxReq = 1'b1;
    @(negedge clk);
    oddRxReq = 1'b0;
  endtask

  task automatic test_overrun;
    logic [7:0] b;
    for (int i = 0; i < 9; i++) begin
      b = 8'(i);
      applyStimulus(1'b0, b, ^b, 1'b1);
      if (i == 5) begin
        vectors++; if (evenRts !== 1'b0) begin miscompares++; $display("[TB] FAIL rts_after6: got %b want 0", evenRts); end
      end
      if (i == 6) begin
        vectors++; if (evenRts !== 1'b1) begin miscompares++; $display("[TB] FAIL rts_after7: got %b want 1", evenRts); end
      end
      if (i == 7) begin
        vectors++; if (evenOvr !== 1'b0) begin miscompares++; $display("[TB] FAIL ovr_after8: got %b want 0", evenOvr); end
      end
      if (i == 8) begin
        vectors++; if (evenOvr !== 1'b1) begin miscompares++; $display("[TB] FAIL ovr_after9: got %b want 1", evenOvr); end
      end
    end
    for (int i = 0; i < 8; i++) begin
      vectors++; if (evenRxRdy !== 1'b1 || evenRxData !== 8'(i)) begin miscompares++; $display("[TB] FAIL pop%0d: got rdy=%b data=%h want rdy=1 data=%h", i, evenRxRdy, evenRxData, 8'(i)); end
      evenRxReq = 1'b1;
      @(negedge clk);
      evenRxReq = 1'b0;
    end
    vectors++; if (evenRxRdy !== 1'b0) begin miscompares++; $display("[TB] FAIL drained_rdy: got %b want 0", evenRxRdy); end
    evenClr = 1'b1;
    @(negedge clk);
    evenClr = 1'b0;
  endtask

  task automatic test_glitch;
    evenRxDrv = 1'b0;
    repeat (4) @(negedge clk);
    evenRxDrv = 1'b1;
    repeat (200) @(negedge clk);
    vectors++; if (evenRxRdy !== 1'b0) begin miscompares++; $display("[TB] FAIL glitch_rdy: got %b want 0", evenRxRdy); end
    vectors++; if ({evenPerr, evenFerr, evenOvr} !== 3'b000) begin miscompares++; $display("[TB] FAIL glitch_flags: got %b want 000", {evenPerr, evenFerr, evenOvr}); end
  endtask

  task automatic test_cts;
    logic [7:0] bytes [3];
    logic [7:0] d;
    logic       p, s;
    bit         found, sawLow;
    bytes[0] = 8'h13;
    bytes[1] = 8'h22;
    bytes[2] = 8'h37;
    evenCts = 1'b1;
    repeat (4) @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      evenTxData = bytes[j];
      evenTxReq = 1'b1;
      @(negedge clk);
    end
    evenTxReq = 1'b0;
    sawLow = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (evenTx !== 1'b1) sawLow = 1'b1;
      @(negedge clk);
    end
    vectors++; if (sawLow !== 1'b0) begin miscompares++; $display("[TB] FAIL cts_hold_line: got low=%b want 0", sawLow); end
    vectors++; if (evenTxFull !== 1'b0) begin miscompares++; $display("[TB] FAIL cts_full: got %b want 0", evenTxFull); end
    vectors++; if (evenTxBusy !== 1'b1) begin miscompares++; $display("[TB] FAIL cts_busy: got %b want 1", evenTxBusy); end
    evenCts = 1'b0;
    for (int j = 0; j < 3; j++) begin
      decode_tx(d, p, s, found);
      vectors++; if (found !== 1'b1 || d !== bytes[j] || p !== ^bytes[j] || s !== 1'b1) begin miscompares++; $display("[TB] FAIL cts_frame%0d: got found=%b d=%h p=%b s=%b want 1 %h %b 1", j, found, d, p, s, bytes[j], ^bytes[j]); end
    end
    // Second burst: CTS rises just after the 0x44 frame has started.
    evenTxData = 8'h44;
    evenTxReq = 1'b1;
    @(negedge clk);
    evenTxData = 8'h55;
    @(negedge clk);
    evenTxReq = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (evenTx === 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    evenCts = 1'b1;
    decode_tx(d, p, s, found);
    vectors++; if (found !== 1'b1 || d !== 8'h44 || s !== 1'b1) begin miscompares++; $display("[TB] FAIL cts_midframe: got found=%b d=%h s=%b want 1 44 1", found, d, s); end
    sawLow = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (evenTx !== 1'b1) sawLow = 1'b1;
      @(negedge clk);
    end
    vectors++; if (sawLow !== 1'b0) begin miscompares++; $display("[TB] FAIL cts_next_held: got low=%b want 0", sawLow); end
    vectors++; if (evenTxBusy !== 1'b1) begin miscompares++; $display("[TB] FAIL cts_queued_busy: got %b want 1", evenTxBusy); end
  endtask

  task automatic test_reset_mid_tx;
    bit found, sawLow;
    evenCts = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (evenTx === 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    vectors++; if (found !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_tx_start: got %b want 1", found); end
    repeat (35) @(negedge clk);
    evenTxData = 8'h66;
    evenTxReq = 1'b1;
    @(negedge clk);
    evenTxReq = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if (evenTx !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_pre_bit: got %b want 0", evenTx); end
    rstN = 1'b0;
    @(negedge clk);
    vectors++; if (evenTx !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_mid_tx: got %b want 1", evenTx); end
    vectors++; if (evenTxBusy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_busy: got %b want 0", evenTxBusy); end
    rstN = 1'b1;
    sawLow = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (evenTx !== 1'b1) sawLow = 1'b1;
      @(negedge clk);
    end
    vectors++; if (sawLow !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_fifo_empty: got low=%b want 0", sawLow); end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_loopback();
    test_frame_error();
    test_parity();
    test_overrun();
    test_glitch();
    test_cts();
    test_reset_mid_tx();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
